// File: rtl/counter_timer_if.sv
// counter_timer_if: control and status bundle for counter_timer.
//   master: drives start/stop/tick numbers, observes count/overflow/running/generated_signal.
//   slave : the counter itself.
interface counter_timer_if #(
    parameter int bitwidth = 8
);
    logic                start;
    logic                stop;
    logic [bitwidth-1:0] tick_number_rising_edge;
    logic [bitwidth-1:0] tick_number_falling_edge;
    logic [bitwidth-1:0] count;
    logic                overflow;
    logic                running;
    logic                generated_signal;

    modport master (
        output start, stop, tick_number_rising_edge, tick_number_falling_edge,
        input  count, overflow, running, generated_signal
    );

    modport slave (
        input  start, stop, tick_number_rising_edge, tick_number_falling_edge,
        output count, overflow, running, generated_signal
    );
endinterface

// File: rtl/counter_timer.sv
// counter_timer: one-shot up-counter with a compare-based pulse generator.
//   clock : system clock, rising edge.
//   reset : asynchronous, active-high; clears all state.
//   bus   : counter_timer_if.slave
//     start/stop                 run request (sampled while idle) / synchronous abort
//     tick_number_rising_edge    count value at which generated_signal is set
//     tick_number_falling_edge   count value at which generated_signal is cleared
//     count/overflow/running     registered count, end-of-run pulse, active flag
//     generated_signal           registered compare output
// A run counts 0..counter_overflow-1, then pulses overflow for one cycle.
module counter_timer #(
    parameter int bitwidth         = 8,
    parameter int counter_overflow = 20
) (
    input logic            clock,
    input logic            reset,
    counter_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [bitwidth-1:0] LAST = bitwidth'(counter_overflow - 1);

    state_t              state, state_next;
    logic [bitwidth-1:0] count_q, count_next;
    logic                overflow_q, overflow_next;
    logic                gen_q, gen_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            gen_q      <= 1'b0;
        end else begin
            state      <= state_next;
            count_q    <= count_next;
            overflow_q <= overflow_next;
            gen_q      <= gen_next;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = '0;
        overflow_next = 1'b0;
        gen_next      = gen_q;
        case (state)
            IDLE: begin
                gen_next = 1'b0;
                if (bus.start && !bus.stop) state_next = RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    gen_next   = 1'b0;
                end else if (count_q == LAST) begin
                    // Wrap edge already counts as not running for the comparator.
                    state_next    = IDLE;
                    overflow_next = 1'b1;
                    gen_next      = 1'b0;
                end else begin
                    count_next = count_q + bitwidth'(1);
                    // Falling compare wins when both tick numbers match.
                    if (count_q == bus.tick_number_falling_edge)
                        gen_next = 1'b0;
                    else if (count_q == bus.tick_number_rising_edge)
                        gen_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.count            = count_q;
    assign bus.overflow         = overflow_q;
    assign bus.running          = (state == RUN);
    assign bus.generated_signal = gen_q;
endmodule

// File: tb/tb_counter_timer.sv
module tb_counter_timer;
    localparam int BW  = 8;
    localparam int OVF = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    counter_timer_if #(.bitwidth(BW)) bus();

    counter_timer #(.bitwidth(BW), .counter_overflow(OVF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic start;
        logic stop;
        int   e_count;
        logic e_run;
        logic e_ovf;
        logic e_gen;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int c, input logic r, input logic o, input logic g);
        check({tag, "_count"},   32'(bus.count),   c);
        check({tag, "_running"}, 32'(bus.running), 32'(r));
        check({tag, "_overflow"},32'(bus.overflow),32'(o));
        check({tag, "_gen"},     32'(bus.generated_signal), 32'(g));
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_ticks(input int rise, input int fall);
        bus.tick_number_rising_edge  = BW'(rise);
        bus.tick_number_falling_edge = BW'(fall);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Full run with a 2-cycle start pulse; lo..hi is the expected high window in count values.
    task automatic run_window(input string tag, input int rise, input int fall, input int lo, input int hi);
        int high;
        high = 0;
        set_ticks(rise, fall);
        bus.start = 1'b1;
        step();
        for (int k = 0; k < OVF; k++) begin
            if (k == 1) bus.start = 1'b0;
            check_outputs($sformatf("%s_k%0d", tag, k), k, 1'b1, 1'b0, (k >= lo && k <= hi));
            if (bus.generated_signal === 1'b1) high++;
            step();
        end
        check_outputs({tag, "_wrap"}, 0, 1'b0, 1'b1, 1'b0);
        step();
        check_outputs({tag, "_after"}, 0, 1'b0, 1'b0, 1'b0);
        check({tag, "_width"}, high, (hi >= lo) ? (hi - lo + 1) : 0);
        step();
        check_outputs({tag, "_hold"}, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, pulses, ovf_seen;
        int m_cnt, r, f;
        bit m_run, m_ovf, s, p, e_gen;

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_ticks(0, 0);

        // Reset state while reset is held
        #2;
        check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        check_outputs("post_reset", 0, 1'b0, 1'b0, 1'b0);

        // Table-driven short sequences, ticks rise=0 fall=2
        vecs[0]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        set_ticks(0, 2);
        for (int i = 0; i < 11; i++) begin
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_run, vecs[i].e_ovf, vecs[i].e_gen);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Basic run and pulse window, then edge-case windows
        run_window("basic", 10, 15, 11, 15);
        run_window("equal", 5, 5, 1, 0);
        run_window("late_fall", 3, 25, 4, 19);
        run_window("late_rise", 20, 25, 1, 0);

        // Stop mid-run at count 7
        set_ticks(10, 15);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        check("stop_pre_count", 32'(bus.count), 7);
        bus.stop = 1'b1;
        step();
        check_outputs("stop", 0, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b0;
        ovf_seen = 0;
        repeat (25) begin
            step();
            if (bus.overflow !== 1'b0) ovf_seen++;
        end
        check("stop_no_overflow", ovf_seen, 0);
        bus.start = 1'b1;
        step();
        check_outputs("restart0", 0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        step();
        check_outputs("restart1", 1, 1'b1, 1'b0, 1'b0);
        apply_reset();

        // Asynchronous reset mid-run at count 12 with the pulse high
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        check("areset_pre_count", 32'(bus.count), 12);
        check("areset_pre_gen", 32'(bus.generated_signal), 1);
        #2 reset = 1'b1;
        #1 check_outputs("areset", 0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_outputs($sformatf("areset_idle%0d", i), 0, 1'b0, 1'b0, 1'b0);
        end

        // Start held high: back-to-back runs
        set_ticks(3, 25);
        bus.start = 1'b1;
        last = -1;
        pulses = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (bus.overflow === 1'b1) begin
                if (last >= 0) check("held_period", cyc - last, 21);
                last = cyc;
                pulses++;
            end
        end
        check("held_pulses", 32'(pulses >= 3), 1);
        bus.start = 1'b0;
        apply_reset();

        // Randomized stimulus against a run-level reference model
        m_run = 0; m_cnt = 0; m_ovf = 0;
        r = 10; f = 15;
        set_ticks(r, f);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e_gen = m_run && (r < m_cnt) && ((f < r) || (m_cnt <= f));
            check_outputs("rnd", m_cnt, m_run, m_ovf, e_gen);
            if (!m_run && $urandom_range(3, 0) == 0) begin
                r = $urandom_range(25, 0);
                f = $urandom_range(25, 0);
                set_ticks(r, f);
            end
            s = ($urandom_range(2, 0) == 0);
            p = ($urandom_range(29, 0) == 0);
            bus.start = s;
            bus.stop  = p;
            m_ovf = 0;
            if (m_run) begin
                if (p) begin
                    m_run = 0; m_cnt = 0;
                end else if (m_cnt == OVF - 1) begin
                    m_run = 0; m_cnt = 0; m_ovf = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (s && !p) begin
                m_run = 1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_timer.md
Name: counter_timer

Overview:
- One-shot up-counter with a compare-based pulse generator.
- Once triggered, the counter runs for `counter_overflow` clock cycles, flags overflow, then returns to idle.
- A registered comparator drives `generated_signal` high between two programmable tick numbers.
- Used as a timing/strobe source in measurement and sequencing logic.

Parameters:
- bitwidth, 8, width of the count and of both tick-number inputs.
- counter_overflow, 20, number of counted cycles per run; legal range 1..2^bitwidth.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  level-sensitive run request, sampled only while idle.
- stop  input  1  synchronous abort; forces idle.
- tick_number_rising_edge  input  bitwidth  count value at which `generated_signal` is set.
- tick_number_falling_edge  input  bitwidth  count value at which `generated_signal` is cleared.
- count  output  bitwidth  current count, registered.
- overflow  output  1  one-cycle pulse at end of run, registered.
- running  output  1  high while the counter is active.
- generated_signal  output  1  registered compare output.

Behaviour:
- Reset (async, any time, including mid-run): count=0, running=0, overflow=0, generated_signal=0.
- Idle (running=0):
  - count holds 0.
  - start=1 and stop=0 at an edge: running<=1, count stays 0.
- Running, at each edge:
  - stop=1: running<=0, count<=0, overflow<=0, generated_signal<=0. Stop has priority over everything else.
  - count==counter_overflow-1: count<=0, running<=0, overflow<=1.
  - Otherwise: count<=count+1.
- Run sequence: the count sequence after the start edge is 0,1,…,counter_overflow-1, so the run lasts exactly counter_overflow cycles.
- overflow: high for exactly the one cycle after the wrap edge; low otherwise. It is never asserted on stop.
- start while running: ignored.
- start held high through the overflow edge: the counter re-arms at the next edge, because overflow clears running and start is sampled again.
- start and stop high together while idle: remains idle.
- Count arithmetic: unsigned, bitwidth bits. No wrap beyond counter_overflow-1 can occur.
- Pulse generator, registered, one-cycle latency from count:
  - running=0 (including the wrap edge): generated_signal<=0.
  - Else if count==tick_number_falling_edge: generated_signal<=0.
  - Else if count==tick_number_rising_edge: generated_signal<=1.
  - Else: generated_signal holds.
- Resulting pulse window: high during the cycles where count = rising+1 … falling. Pulse width = falling − rising cycles.
- rising==falling: output never asserts (falling wins).
- falling < rising, or falling ≥ counter_overflow: the output stays high from rising+1 until the end of the run, then clears.
- rising ≥ counter_overflow: never asserts.
- Tick-number inputs are sampled every cycle. Changing them mid-run takes effect at the next compare.

Test Plan:
- Basic run (bitwidth=8, counter_overflow=20, rising=10, falling=15, start pulsed 2 cycles):
  - count walks 0..19.
  - overflow high for 1 cycle when count returns to 0.
  - running then low; count holds 0 afterwards.
- Pulse window, same setup:
  - generated_signal rises the cycle count shows 11 and falls the cycle after count shows 15.
  - High for exactly 5 cycles.
- Stop mid-run: assert stop while count==7.
  - Next cycle count=0, running=0, generated_signal=0.
  - overflow never asserts.
  - A new start restarts from 0.
- Async reset mid-run: assert reset between edges while count==12 and generated_signal=1.
  - All outputs are 0 immediately, before the next edge.
  - After release, the block stays idle until start.
- Edge cases:
  - rising=falling=5: generated_signal stays 0.
  - rising=3, falling=25: high from count 4 to 19, cleared at wrap.
  - start held high continuously: back-to-back runs, one overflow pulse every 21 cycles (20 counted cycles + 1 idle re-arm cycle).
